sync_ram_2p: RTL

Parametrised simple-dual-port synchronous RAM: one write port and one independent read port on a single clock. Adds per-byte write enables, selectable read-during-write behaviour, 1- or 2-cycle read latency with a `rd_valid` strobe, and an optional hardware clear sequence after reset. Intended as the general-purpose on-chip storage block for buffers and register files that previously used the single-address RAM.

---
 rtl/sync_ram_2p_pkg.sv | 17 +
 rtl/sync_ram_2p_if.sv | 29 ++
 rtl/sync_ram_2p_rd_pipe.sv | 37 +++
 rtl/sync_ram_2p.sv | 91 +++++++++
 4 files changed

// File: rtl/sync_ram_2p_pkg.sv
// Shared definitions for the simple-dual-port RAM family.
package sync_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    // Number of byte lanes in a word of the given width.
    function automatic int nbytes(int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sync_ram_2p_if.sv
// Request/response bundle of sync_ram_2p: one write port, one read port.
interface sync_ram_2p_if
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);

    logic                            we;
    logic [nbytes(DATA_WIDTH)-1:0]   wbe;
    logic [ADDR_WIDTH-1:0]           waddr;
    logic [DATA_WIDTH-1:0]           din;
    logic                            re;
    logic [ADDR_WIDTH-1:0]           raddr;
    logic [DATA_WIDTH-1:0]           dout;
    logic                            rd_valid;
    logic                            init_busy;

    modport master (
        output we, wbe, waddr, din, re, raddr,
        input  dout, rd_valid, init_busy
    );

    modport slave (
        input  we, wbe, waddr, din, re, raddr,
        output dout, rd_valid, init_busy
    );

endinterface

// File: rtl/sync_ram_2p_rd_pipe.sv
// Read result pipeline: 1 or 2 register stages carrying data plus valid.
// Data stages load only with a valid beat so the output holds the last
// read result between reads; reset flushes every stage to zero.
module sync_ram_rd_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [RD_LATENCY-1:0]                 vld_pipe;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe;

    // Shift valid every cycle; advance data only behind a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            if (in_vld) dat_pipe[0] <= in_data;
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign out_vld  = vld_pipe[RD_LATENCY-1];
    assign out_data = dat_pipe[RD_LATENCY-1];

endmodule

// File: rtl/sync_ram_2p.sv
// Simple-dual-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, 1/2-cycle read latency and optional
// post-reset clear sequence.
module sync_ram_2p
    import sync_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = RDW_READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    sync_ram_2p_if.slave  bus
);

    localparam int NB    = nbytes(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("sync_ram_2p: DATA_WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sync_ram_2p: RD_LATENCY must be 1 or 2");
    end

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] ctr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_en;
    logic                  last_clear;

    // Clear sequence state and address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
            ctr   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_INIT) ctr <= ctr + ADDR_WIDTH'(1);
        end
    end

    // Leave INIT on the edge that clears the last word.
    always_comb begin
        state_nx   = state;
        last_clear = (ctr == ADDR_WIDTH'(DEPTH - 1));
        if (state == ST_INIT && last_clear) state_nx = ST_READY;
    end

    // Storage: zero fill during INIT, byte-lane writes once READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[ctr] <= '0;
            end else if (bus.we) begin
                for (int i = 0; i < NB; i++)
                    if (bus.wbe[i]) mem[bus.waddr][8*i +: 8] <= bus.din[8*i +: 8];
            end
        end
    end

    // Read word; write-first mode forwards the enabled lanes of a
    // colliding write, read-first sees the array before the write lands.
    always_comb begin
        rd_word = mem[bus.raddr];
        if (RDW_MODE == RDW_WRITE_FIRST && bus.we && bus.waddr == bus.raddr) begin
            for (int i = 0; i < NB; i++)
                if (bus.wbe[i]) rd_word[8*i +: 8] = bus.din[8*i +: 8];
        end
    end

    assign rd_en = (state == ST_READY) && bus.re;

    sync_ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_en),
        .in_data  (rd_word),
        .out_vld  (bus.rd_valid),
        .out_data (bus.dout)
    );

    assign bus.init_busy = (state == ST_INIT);

endmodule
